// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: synchronises and debounces the rows and
// emits one registered strobe with a 4-bit key code per debounced press.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] linhas,
    output logic [3:0] colunas,
    output logic       insere,
    output logic [3:0] entrada,
    output logic       tecla_ativa
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_REL} state_t;

    state_t        state, state_n;
    logic [1:0]    col, col_n;
    logic [1:0]    row, row_n;
    logic [DW-1:0] div, div_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]    rs_meta, rs;
    logic          insere_n, tecla_n;
    logic [3:0]    entrada_n;
    logic [1:0]    low_row;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b0000: key_code = 4'h1;
            4'b0001: key_code = 4'h2;
            4'b0010: key_code = 4'h3;
            4'b0011: key_code = 4'hA;
            4'b0100: key_code = 4'h4;
            4'b0101: key_code = 4'h5;
            4'b0110: key_code = 4'h6;
            4'b0111: key_code = 4'hB;
            4'b1000: key_code = 4'h7;
            4'b1001: key_code = 4'h8;
            4'b1010: key_code = 4'h9;
            4'b1011: key_code = 4'hC;
            4'b1100: key_code = 4'hE;
            4'b1101: key_code = 4'h0;
            4'b1110: key_code = 4'hF;
            default: key_code = 4'hD;
        endcase
    endfunction

    always_comb begin
        colunas = ~(4'b0001 << col);
        cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
        if (!rs[0])      low_row = 2'd0;
        else if (!rs[1]) low_row = 2'd1;
        else if (!rs[2]) low_row = 2'd2;
        else             low_row = 2'd3;
    end

    always_comb begin
        state_n   = state;
        col_n     = col;
        row_n     = row;
        div_n     = div;
        cnt_n     = cnt;
        insere_n  = 1'b0;
        entrada_n = entrada;
        tecla_n   = tecla_ativa;
        case (state)
            SCAN: begin
                if (div == DIV_LAST) begin
                    div_n = '0;
                    if (rs != 4'hF) begin
                        row_n   = low_row;
                        cnt_n   = CW'(1);
                        state_n = DEBOUNCE;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end else begin
                    div_n = div + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!rs[row]) begin
                    if (cnt >= CNT_LAST) begin
                        cnt_n     = '0;
                        insere_n  = 1'b1;
                        entrada_n = key_code(row, col);
                        tecla_n   = 1'b1;
                        state_n   = EMIT;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end else begin
                    cnt_n   = '0;
                    div_n   = '0;
                    col_n   = col + 2'd1;
                    state_n = SCAN;
                end
            end
            EMIT: begin
                cnt_n   = '0;
                state_n = WAIT_REL;
            end
            default: begin
                // Release needs the whole frozen column idle, so a second key
                // still held in this column cannot be re-detected as a new press.
                if (rs == 4'hF) begin
                    if (cnt >= CNT_LAST) begin
                        cnt_n   = '0;
                        div_n   = '0;
                        col_n   = col + 2'd1;
                        tecla_n = 1'b0;
                        state_n = SCAN;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end else begin
                    cnt_n = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SCAN;
            col         <= '0;
            row         <= '0;
            div         <= '0;
            cnt         <= '0;
            rs_meta     <= '1;
            rs          <= '1;
            insere      <= 1'b0;
            entrada     <= '0;
            tecla_ativa <= 1'b0;
        end else begin
            state       <= state_n;
            col         <= col_n;
            row         <= row_n;
            div         <= div_n;
            cnt         <= cnt_n;
            rs_meta     <= linhas;
            rs          <= rs_meta;
            insere      <= insere_n;
            entrada     <= entrada_n;
            tecla_ativa <= tecla_n;
        end
    end

endmodule
